// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU units, the result stage and accumulator writeback.
// The stage uses the slave side; the upstream/downstream driver uses the master side.
interface alu_result_stage_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] Out0;
  logic [WIDTH-1:0] Out1;
  logic [WIDTH-1:0] Out2;
  logic [WIDTH-1:0] Out3;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Neg;
  logic             Carry;
  logic [CNT_W-1:0] txn_count;

  modport master (
    output in_valid, op, Out0, Out1, Out2, Out3, carry_in, out_ready,
    input  in_ready, out_valid, Result, Zero, Neg, Carry, txn_count
  );

  modport slave (
    input  in_valid, op, Out0, Out1, Out2, Out3, carry_in, out_ready,
    output in_ready, out_valid, Result, Zero, Neg, Carry, txn_count
  );
endinterface

// File: rtl/alu_result_stage.sv
// Selects one ALU unit result per opcode, adds Zero/Neg/Carry flags and buffers it in a 2-entry skid buffer.
// Latency 1 cycle, 1 beat/cycle; in_ready is registered and drops only when both entries are full.
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_stage_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             neg;
    logic             carry;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state;
  entry_t           head;
  entry_t           tail;
  entry_t           new_entry;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] sel;
  logic             acc;
  logic             deq;

  always_comb begin
    sel = '0;
    case (bus.op)
      2'b00:   sel = bus.Out0;
      2'b01:   sel = bus.Out1;
      2'b10:   sel = bus.Out2;
      default: sel = bus.Out3;
    endcase
    new_entry.res   = sel;
    new_entry.zero  = ~|sel;
    new_entry.neg   = sel[WIDTH-1];
    // Only the adder/subtractor produce a meaningful carry.
    new_entry.carry = ~bus.op[1] & bus.carry_in;
  end

  assign acc = bus.in_valid & in_ready_q;
  assign deq = out_valid_q & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      head        <= '0;
      tail        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      count       <= '0;
    end else begin
      if (deq) begin
        count <= count + 1'b1;
      end
      case (state)
        EMPTY: begin
          if (acc) begin
            head        <= new_entry;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (acc && !deq) begin
            tail       <= new_entry;
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (!acc && deq) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (acc && deq) begin
            head <= new_entry;
          end
        end
        TWO: begin
          if (deq) begin
            head       <= tail;
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Result    = head.res;
  assign bus.Zero      = head.zero;
  assign bus.Neg       = head.neg;
  assign bus.Carry     = head.carry;
  assign bus.txn_count = count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed vector table, hand sequences and random traffic against a queue model.
module tb_alu_result_stage;

  logic clk;
  logic rst_n;

  alu_result_stage_if #(.WIDTH(8), .CNT_W(8)) bus ();

  alu_result_stage #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
  } ent_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] o0, o1, o2, o3;
    logic       cin;
    logic [7:0] res;
    logic       z, n, c;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  ent_t q[$];
  int   mcount   = 0;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t ref_ent(input logic [1:0] op, input logic [7:0] o0, input logic [7:0] o1,
                                   input logic [7:0] o2, input logic [7:0] o3, input logic cin);
    ent_t e;
    int   v;
    v = (op == 0) ? int'(o0) : (op == 1) ? int'(o1) : (op == 2) ? int'(o2) : int'(o3);
    e.res = 8'(v);
    e.z   = (v == 0);
    e.n   = (v >= 128);
    e.c   = (op < 2) ? cin : 1'b0;
    return e;
  endfunction

  // Check the DUT against the model, drive one cycle of stimulus, advance the model, step the clock.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [7:0] o0, input logic [7:0] o1,
                       input logic [7:0] o2, input logic [7:0] o3, input logic cin, input logic ordy);
    logic acc;
    logic deq;
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("txn_count", 32'(bus.txn_count), 32'(mcount % 256));
    if (q.size() != 0) begin
      chk("Result", 32'(bus.Result), 32'(q[0].res));
      chk("Zero", 32'(bus.Zero), 32'(q[0].z));
      chk("Neg", 32'(bus.Neg), 32'(q[0].n));
      chk("Carry", 32'(bus.Carry), 32'(q[0].c));
    end
    bus.in_valid  = v;
    bus.op        = op;
    bus.Out0      = o0;
    bus.Out1      = o1;
    bus.Out2      = o2;
    bus.Out3      = o3;
    bus.carry_in  = cin;
    bus.out_ready = ordy;
    acc = v && (q.size() < 2);
    deq = ordy && (q.size() != 0);
    if (deq) begin
      void'(q.pop_front());
      mcount++;
    end
    if (acc) q.push_back(ref_ent(op, o0, o1, o2, o3, cin));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, ordy);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_Result"}, 32'(bus.Result), 32'd0);
    chk({tag, "_flags"}, 32'({bus.Zero, bus.Neg, bus.Carry}), 32'd0);
    chk({tag, "_txn_count"}, 32'(bus.txn_count), 32'd0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'd0;
    bus.Out0      = 8'h00;
    bus.Out1      = 8'h00;
    bus.Out2      = 8'h00;
    bus.Out3      = 8'h00;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    q.delete();
    mcount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{op: 2'd3, o0: 8'hA5, o1: 8'hA5, o2: 8'hA5, o3: 8'h00, cin: 1'b0, res: 8'h00, z: 1'b1, n: 1'b0, c: 1'b0};
    vt[1] = '{op: 2'd0, o0: 8'h80, o1: 8'h01, o2: 8'h02, o3: 8'h03, cin: 1'b1, res: 8'h80, z: 1'b0, n: 1'b1, c: 1'b1};
    vt[2] = '{op: 2'd2, o0: 8'hFF, o1: 8'hFF, o2: 8'h5A, o3: 8'hFF, cin: 1'b1, res: 8'h5A, z: 1'b0, n: 1'b0, c: 1'b0};
    vt[3] = '{op: 2'd1, o0: 8'h00, o1: 8'hFF, o2: 8'h00, o3: 8'h00, cin: 1'b0, res: 8'hFF, z: 1'b0, n: 1'b1, c: 1'b0};
    vt[4] = '{op: 2'd1, o0: 8'h77, o1: 8'h00, o2: 8'h77, o3: 8'h77, cin: 1'b1, res: 8'h00, z: 1'b1, n: 1'b0, c: 1'b1};
    vt[5] = '{op: 2'd2, o0: 8'h11, o1: 8'h22, o2: 8'h00, o3: 8'h44, cin: 1'b1, res: 8'h00, z: 1'b1, n: 1'b0, c: 1'b0};
    vt[6] = '{op: 2'd3, o0: 8'h00, o1: 8'h00, o2: 8'h00, o3: 8'hC3, cin: 1'b1, res: 8'hC3, z: 1'b0, n: 1'b1, c: 1'b0};
    vt[7] = '{op: 2'd0, o0: 8'h7F, o1: 8'h80, o2: 8'h80, o3: 8'h80, cin: 1'b0, res: 8'h7F, z: 1'b0, n: 1'b0, c: 1'b0};

    do_reset();

    // Directed vectors, streamed with out_ready high: each result appears one cycle after acceptance.
    foreach (vt[i]) begin
      cycle(1'b1, vt[i].op, vt[i].o0, vt[i].o1, vt[i].o2, vt[i].o3, vt[i].cin, 1'b1);
      chk("vec_valid", 32'(bus.out_valid), 32'd1);
      chk("vec_Result", 32'(bus.Result), 32'(vt[i].res));
      chk("vec_flags", 32'({bus.Zero, bus.Neg, bus.Carry}), 32'({vt[i].z, vt[i].n, vt[i].c}));
      if (i == 1) chk("vec_txn_after_first", 32'(bus.txn_count), 32'd1);
    end
    idle(1'b1);
    idle(1'b1);

    // Backpressure fill: third beat held while full must not be captured until space frees up.
    cycle(1'b1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h22, 1'b0, 1'b0);
    chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
    cycle(1'b1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h33, 1'b0, 1'b0);
    chk("bp_head_held", 32'(bus.Result), 32'h11);
    cycle(1'b1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h33, 1'b0, 1'b1);
    chk("bp_second", 32'(bus.Result), 32'h22);
    cycle(1'b1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h33, 1'b0, 1'b1);
    chk("bp_third", 32'(bus.Result), 32'h33);
    idle(1'b1);
    idle(1'b1);

    // Streaming: 16 beats, op cycling, distinct values.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 2'(i), 8'(8'h10 + i), 8'(8'h40 + i), 8'(8'h90 + i), 8'(8'hC0 + i), 1'(i), 1'b1);
    end
    idle(1'b1);
    idle(1'b1);

    // Counter wrap: 257 delivered results from a fresh reset.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      cycle(1'b1, 2'd0, 8'(i), 8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    end
    idle(1'b1);
    chk("wrap_txn_count", 32'(bus.txn_count), 32'd1);

    // Reset between edges while two entries are held.
    cycle(1'b1, 2'd2, 8'h00, 8'h00, 8'hAA, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 2'd2, 8'h00, 8'h00, 8'hBB, 8'h00, 1'b0, 1'b0);
    chk("mid_in_ready_full", 32'(bus.in_ready), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    q.delete();
    mcount = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
